// File: rtl/id_pkg.sv
// Shared types for the IF->ID instruction buffer: entry layout and buffer state.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package id_pkg;

    localparam int IB_ADDR_W = 32;
    localparam int IB_INST_W = 32;

    // One buffered fetch slot.
    typedef struct packed {
        logic [IB_ADDR_W-1:0] pc;
        logic [IB_INST_W-1:0] inst;
    } ibuf_entry_t;

    // NORMAL: regular queueing. WAIT_DS: a taken branch was consumed before its
    // delay slot arrived; the next accepted fetch slot 0 is that delay slot.
    typedef enum logic {
        IB_NORMAL  = 1'b0,
        IB_WAIT_DS = 1'b1
    } ibuf_state_t;

endpackage

// File: rtl/id_inst_buffer_if.sv
// Fetch-side push bus and decode-side issue bus of the instruction buffer.
// Latency: n/a (wiring only).
// Backpressure: fetch_ready_o gates pushes; issue side consumes via issue_num_i.
interface id_inst_buffer_if #(
    parameter int DEPTH   = 16,
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2,
    parameter int ADDR_W  = 32
) ();

    localparam int FNUM_W = $clog2(FETCH_W + 1);
    localparam int INUM_W = $clog2(ISSUE_W + 1);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    // fetch side
    logic [FNUM_W-1:0]         fetch_num_i;
    logic [FETCH_W*ADDR_W-1:0] fetch_pc_i;
    logic [FETCH_W*32-1:0]     fetch_inst_i;
    logic                      fetch_ready_o;

    // decode side
    logic [ISSUE_W-1:0]        issue_valid_o;
    logic [ISSUE_W*ADDR_W-1:0] issue_pc_o;
    logic [ISSUE_W*32-1:0]     issue_inst_o;
    logic [INUM_W-1:0]         issue_num_i;
    logic                      branch_taken_i;
    logic                      flush_i;
    logic [CNT_W-1:0]          occupancy_o;

    // IF/ID pipeline side driving the buffer
    modport master (
        output fetch_num_i, fetch_pc_i, fetch_inst_i,
        output issue_num_i, branch_taken_i, flush_i,
        input  fetch_ready_o, issue_valid_o, issue_pc_o, issue_inst_o, occupancy_o
    );

    // the buffer itself
    modport slave (
        input  fetch_num_i, fetch_pc_i, fetch_inst_i,
        input  issue_num_i, branch_taken_i, flush_i,
        output fetch_ready_o, issue_valid_o, issue_pc_o, issue_inst_o, occupancy_o
    );

endinterface

// File: rtl/id_inst_buffer.sv
// Circular instruction queue between IF and ID with taken-branch delay-slot keep and flush.
// Latency: 1 cycle from accepted push to visibility on the issue outputs.
// Backpressure: fetch_ready_o drops when fewer than FETCH_W entries are free; IF must hold.
module id_inst_buffer
    import id_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2,
    parameter int ADDR_W  = IB_ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    id_inst_buffer_if.slave    bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    ibuf_entry_t mem [DEPTH];

    ptr_t        head_q, head_nxt;
    ptr_t        tail_q, tail_nxt;
    cnt_t        count_q, count_nxt;
    ibuf_state_t state_q, state_nxt;

    cnt_t fetch_n;
    cnt_t issue_n;
    cnt_t pop_n;
    cnt_t push_n;
    cnt_t rem_n;
    cnt_t wr_n;
    logic fetch_ready;
    logic br_eff;

    logic [ISSUE_W-1:0]        issue_valid;
    logic [ISSUE_W*ADDR_W-1:0] issue_pc;
    logic [ISSUE_W*32-1:0]     issue_inst;
    ptr_t                      rd_idx;

    // Clamp requested push/pop amounts against free space and occupancy.
    always_comb begin
        fetch_n     = (cnt_t'(bus.fetch_num_i) > cnt_t'(FETCH_W)) ? cnt_t'(FETCH_W)
                                                                  : cnt_t'(bus.fetch_num_i);
        issue_n     = cnt_t'(bus.issue_num_i);
        fetch_ready = (cnt_t'(DEPTH) - count_q) >= cnt_t'(FETCH_W);
        pop_n       = (issue_n < count_q) ? issue_n : count_q;
        push_n      = fetch_ready ? fetch_n : '0;
        rem_n       = count_q - pop_n;
        // a branch with nothing actually consumed has no delay slot to protect
        br_eff      = bus.branch_taken_i && (pop_n != '0);
    end

    // Next pointer/count/state and number of fetch slots written this cycle.
    always_comb begin
        head_nxt  = head_q;
        tail_nxt  = tail_q;
        count_nxt = count_q;
        state_nxt = state_q;
        wr_n      = '0;
        if (bus.flush_i) begin
            head_nxt  = '0;
            tail_nxt  = '0;
            count_nxt = '0;
            state_nxt = IB_NORMAL;
        end else if (br_eff) begin
            head_nxt  = head_q + ptr_t'(pop_n);
            state_nxt = IB_NORMAL;
            if (rem_n != '0) begin
                // delay slot already buffered at the new head: keep it alone
                tail_nxt  = head_nxt + ptr_t'(1);
                count_nxt = cnt_t'(1);
            end else if (push_n != '0) begin
                // delay slot arriving now in fetch slot 0; head_nxt == tail_q here
                wr_n      = cnt_t'(1);
                tail_nxt  = tail_q + ptr_t'(1);
                count_nxt = cnt_t'(1);
            end else begin
                count_nxt = '0;
                state_nxt = IB_WAIT_DS;
            end
        end else begin
            case (state_q)
                IB_WAIT_DS: begin
                    if (push_n != '0) begin
                        wr_n      = cnt_t'(1);
                        state_nxt = IB_NORMAL;
                    end
                end
                IB_NORMAL: begin
                    wr_n = push_n;
                end
            endcase
            head_nxt  = head_q + ptr_t'(pop_n);
            tail_nxt  = tail_q + ptr_t'(wr_n);
            count_nxt = count_q - pop_n + wr_n;
        end
    end

    // Pointer, count and state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= IB_NORMAL;
        end else begin
            head_q  <= head_nxt;
            tail_q  <= tail_nxt;
            count_q <= count_nxt;
            state_q <= state_nxt;
        end
    end

    // Entry storage; slots beyond wr_n are not written. Contents are only read while counted valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_W; i++) begin
            if (cnt_t'(i) < wr_n) begin
                mem[tail_q + ptr_t'(i)].pc   <= IB_ADDR_W'(bus.fetch_pc_i[i*ADDR_W +: ADDR_W]);
                mem[tail_q + ptr_t'(i)].inst <= bus.fetch_inst_i[i*32 +: 32];
            end
        end
    end

    // Present the oldest ISSUE_W entries; invalid lanes read as zero (nop).
    always_comb begin
        issue_valid = '0;
        issue_pc    = '0;
        issue_inst  = '0;
        rd_idx      = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            rd_idx = head_q + ptr_t'(i);
            if (cnt_t'(i) < count_q) begin
                issue_valid[i]                = 1'b1;
                issue_pc[i*ADDR_W +: ADDR_W]  = ADDR_W'(mem[rd_idx].pc);
                issue_inst[i*32 +: 32]        = mem[rd_idx].inst;
            end
        end
    end

    assign bus.fetch_ready_o = fetch_ready;
    assign bus.occupancy_o   = count_q;
    assign bus.issue_valid_o = issue_valid;
    assign bus.issue_pc_o    = issue_pc;
    assign bus.issue_inst_o  = issue_inst;

endmodule
